// File: rtl/ft_tx_sched.sv
// Round-robin packet scheduler in front of the FT232H TX FIFO write port; frames SYNC, ID, LEN_HI, LEN_LO, payload.
// Define FT_TX_CSUM_EN to append an XOR checksum byte after the payload.
module ft_tx_sched #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ID0       = 8'h01,
  parameter logic [7:0] ID1       = 8'h02
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        s0_req,
  input  logic [15:0] s0_len,
  input  logic [7:0]  s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  output logic        s0_gnt,
  input  logic        s1_req,
  input  logic [15:0] s1_len,
  input  logic [7:0]  s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic        s1_gnt,
  input  logic        tx_full,
  output logic        tx_wrreq,
  output logic [7:0]  tx_data,
  output logic        busy
);

`ifdef FT_TX_CSUM_EN
  typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_ID, HDR_LH, HDR_LL, DATA, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_ID, HDR_LH, HDR_LL, DATA} state_t;
`endif

  state_t            state;
  logic              sel, last_gnt, pick, wr;
  logic [1:0]        gnt, req, vld, rdy;
  logic [1:0][15:0]  len;
  logic [1:0][7:0]   dat;
  logic [15:0]       len_q, rem;
`ifdef FT_TX_CSUM_EN
  logic [7:0]        csum;
`endif

  assign req = {s1_req, s0_req};
  assign vld = {s1_valid, s0_valid};
  assign len = {s1_len, s0_len};
  assign dat = {s1_data, s0_data};
  assign {s1_ready, s0_ready} = rdy;
  assign {s1_gnt, s0_gnt} = gnt;
  assign busy = (state != IDLE);

  // Under contention the source not served last wins; a lone requester always wins.
  assign pick = (&req) ? ~last_gnt : req[1];

  always_comb begin
    wr      = 1'b0;
    rdy     = '0;
    tx_data = 8'h00;
    case (state)
      HDR_SYNC: begin wr = !tx_full; tx_data = SYNC_BYTE; end
      HDR_ID:   begin wr = !tx_full; tx_data = sel ? ID1 : ID0; end
      HDR_LH:   begin wr = !tx_full; tx_data = len_q[15:8]; end
      HDR_LL:   begin wr = !tx_full; tx_data = len_q[7:0]; end
      DATA: begin
        wr       = vld[sel] & !tx_full;
        rdy[sel] = !tx_full;
        tx_data  = dat[sel];
      end
`ifdef FT_TX_CSUM_EN
      CSUM:     begin wr = !tx_full; tx_data = csum; end
`endif
      default: ;
    endcase
  end
  assign tx_wrreq = wr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      gnt      <= '0;
      last_gnt <= 1'b1;
      len_q    <= '0;
      rem      <= '0;
`ifdef FT_TX_CSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: if (|req) begin
          sel      <= pick;
          last_gnt <= pick;
          gnt      <= pick ? 2'b10 : 2'b01;
          len_q    <= len[pick];
          rem      <= len[pick];
`ifdef FT_TX_CSUM_EN
          csum     <= 8'h00;
`endif
          state    <= HDR_SYNC;
        end
        HDR_SYNC: if (wr) state <= HDR_ID;
        HDR_ID:   if (wr) state <= HDR_LH;
        HDR_LH:   if (wr) state <= HDR_LL;
        HDR_LL: if (wr) begin
          if (len_q != 16'd0) state <= DATA;
          else begin
`ifdef FT_TX_CSUM_EN
            state <= CSUM;
`else
            state <= IDLE;
            gnt   <= '0;
`endif
          end
        end
        DATA: if (wr) begin
          rem <= rem - 16'd1;
`ifdef FT_TX_CSUM_EN
          csum <= csum ^ dat[sel];
`endif
          if (rem == 16'd1) begin
`ifdef FT_TX_CSUM_EN
            state <= CSUM;
`else
            state <= IDLE;
            gnt   <= '0;
`endif
          end
        end
`ifdef FT_TX_CSUM_EN
        CSUM: if (wr) begin
          state <= IDLE;
          gnt   <= '0;
        end
`endif
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft_tx_sched.sv
// Bench for ft_tx_sched: table-driven packet scenarios, hand sequences for stalls/reset, and randomized traffic
// checked against a packet-level model of the framed byte stream and round-robin grant order.
module tb_ft_tx_sched;
  logic clk = 1'b0, nrst = 1'b0;
  logic s0_req = 0, s1_req = 0, s0_valid = 0, s1_valid = 0;
  logic [15:0] s0_len = 0, s1_len = 0;
  logic [7:0] s0_data = 0, s1_data = 0, tx_data;
  logic s0_ready, s1_ready, s0_gnt, s1_gnt, tx_wrreq, busy, tx_full;

  always #5 clk = ~clk;

  ft_tx_sched dut (
    .clk(clk), .nrst(nrst),
    .s0_req(s0_req), .s0_len(s0_len), .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_gnt(s0_gnt),
    .s1_req(s1_req), .s1_len(s1_len), .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_gnt(s1_gnt),
    .tx_full(tx_full), .tx_wrreq(tx_wrreq), .tx_data(tx_data), .busy(busy)
  );

  int ncmp = 0, nbad = 0;
  // source-side stimulus queues (what the requesters still have to offer)
  int len0[$], len1[$];
  logic [7:0] pay0[$], pay1[$];
  // model queues: packets as submitted, consumed by the reference
  int m_len0[$], m_len1[$];
  logic [7:0] m_pay0[$], m_pay1[$];
  int mlast = 1;
  logic [7:0] expq[$], cap[$];
  int exp_ord[$], gnt_ord[$], cap_cyc[$], gnt_cyc[$];
  int cyc = 0, wr_full_err = 0, both_gnt_err = 0, rdy1_cnt = 0;
  int vmode = 0;
  bit fmode = 0, force_full = 0, rnd_full = 0, vtog = 0, prev_g0 = 0, prev_g1 = 0;

  assign tx_full = force_full | (fmode & rnd_full);

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: what happens at the coming rising edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (nrst) begin
      if (tx_wrreq) begin
        cap.push_back(tx_data);
        cap_cyc.push_back(cyc);
        if (tx_full) wr_full_err++;
      end
      if (s0_valid && s0_ready && pay0.size() > 0) void'(pay0.pop_front());
      if (s1_valid && s1_ready && pay1.size() > 0) void'(pay1.pop_front());
      if (s1_ready) rdy1_cnt++;
      if (s0_gnt && s1_gnt) both_gnt_err++;
      if (s0_gnt && !prev_g0) begin
        gnt_ord.push_back(0); gnt_cyc.push_back(cyc);
        if (len0.size() > 0) void'(len0.pop_front());
      end
      if (s1_gnt && !prev_g1) begin
        gnt_ord.push_back(1); gnt_cyc.push_back(cyc);
        if (len1.size() > 0) void'(len1.pop_front());
      end
    end
    prev_g0 = s0_gnt;
    prev_g1 = s1_gnt;
  end

  // source drivers, updated just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    vtog = ~vtog;
    rnd_full = ($urandom_range(3) == 0);
    s0_req = (len0.size() > 0);
    s0_len = s0_req ? 16'(len0[0]) : 16'h0;
    s0_data = (pay0.size() > 0) ? pay0[0] : 8'h00;
    s0_valid = (pay0.size() > 0) && (vmode == 0 || (vmode == 1 ? vtog : ($urandom_range(1) == 1)));
    s1_req = (len1.size() > 0);
    s1_len = s1_req ? 16'(len1[0]) : 16'h0;
    s1_data = (pay1.size() > 0) ? pay1[0] : 8'h00;
    s1_valid = (pay1.size() > 0) && (vmode == 0 || (vmode == 1 ? ~vtog : ($urandom_range(1) == 1)));
  end

  task automatic push_byte(input int src, input logic [7:0] b);
    if (src == 0) begin pay0.push_back(b); m_pay0.push_back(b); end
    else begin pay1.push_back(b); m_pay1.push_back(b); end
  endtask

  task automatic add_pkt(input int src, input int n);
    for (int i = 0; i < n; i++) push_byte(src, 8'($urandom_range(255)));
    if (src == 0) begin len0.push_back(n); m_len0.push_back(n); end
    else begin len1.push_back(n); m_len1.push_back(n); end
  endtask

  // Reference: packets leave in round-robin order, each framed as header + payload (+ XOR).
  task automatic build_exp();
    while (m_len0.size() > 0 || m_len1.size() > 0) begin
      int s, n;
      logic [7:0] cs, b;
      if (m_len0.size() > 0 && m_len1.size() > 0) s = (mlast == 0) ? 1 : 0;
      else s = (m_len0.size() > 0) ? 0 : 1;
      mlast = s;
      exp_ord.push_back(s);
      n = (s == 1) ? m_len1.pop_front() : m_len0.pop_front();
      expq.push_back(8'hA5);
      expq.push_back((s == 1) ? 8'h02 : 8'h01);
      expq.push_back(8'(n >> 8));
      expq.push_back(8'(n));
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
        b = (s == 1) ? m_pay1.pop_front() : m_pay0.pop_front();
        cs ^= b;
        expq.push_back(b);
      end
`ifdef FT_TX_CSUM_EN
      expq.push_back(cs);
`endif
    end
  endtask

  task automatic run_batch(input string nm, input int maxcyc);
    bit done = 0;
    build_exp();
    for (int c = 0; c < maxcyc && !done; c++) begin
      @(negedge clk); #1;
      if (cap.size() >= expq.size() && !busy && len0.size() == 0 && len1.size() == 0) done = 1;
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_nbytes"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), cap[i], expq[i]);
    chk({nm, "_npkts"}, gnt_ord.size(), exp_ord.size());
    for (int i = 0; i < exp_ord.size() && i < gnt_ord.size(); i++)
      chk($sformatf("%s_gnt%0d", nm, i), gnt_ord[i], exp_ord[i]);
    expq.delete(); exp_ord.delete();
  endtask

  task automatic clr_cap();
    cap.delete(); cap_cyc.delete(); gnt_ord.delete(); gnt_cyc.delete();
  endtask

  task automatic do_reset();
    nrst = 0;
    len0.delete(); len1.delete(); pay0.delete(); pay1.delete();
    m_len0.delete(); m_len1.delete(); m_pay0.delete(); m_pay1.delete();
    clr_cap();
    mlast = 1;
    repeat (2) @(posedge clk);
    #1 nrst = 1;
  endtask

  task automatic wait_cap(input int n, input string nm);
    bit ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk); #1;
      if (cap.size() >= n) ok = 1;
    end
    chk(nm, int'(ok), 1);
  endtask

  typedef struct {
    bit rst; int n0; int n1; int l0; int l1; int vm; bit fm; int first; bit nordy1;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int span, r0, nb;
    logic [7:0] t1[3];
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h44;
`ifdef FT_TX_CSUM_EN
    nb = 8;
`else
    nb = 7;
`endif
    // rst  n0 n1  l0   l1  vm fm first nordy1
    tbl[0] = '{1, 2, 2, 5,   3, 0, 0, 0, 0};  // simultaneous reqs after reset: 0,1,0,1
    tbl[1] = '{0, 0, 1, 0,   0, 0, 0, 1, 1};  // zero-length src1 packet
    tbl[2] = '{0, 1, 0, 256, 0, 1, 0, 0, 0};  // 256 bytes, valid toggling
    tbl[3] = '{0, 3, 3, 7,   1, 2, 1, 1, 0};  // last grant was src0, so src1 leads
    tbl[4] = '{1, 1, 1, 0,   2, 2, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {s1_gnt, s0_gnt}, 0);
    chk("rst_wrreq", tx_wrreq, 0);
    chk("rst_ready", {s1_ready, s0_ready}, 0);
    nrst = 1;
    @(negedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_wrreq", tx_wrreq, 0);

    // packet 11,22,44 with no back-pressure
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_byte(0, t1[i]);
    len0.push_back(3); m_len0.push_back(3);
    run_batch("t1", 200);
    span = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[0] : -1;
    chk("t1_consecutive", span, nb - 1);
    chk("t1_sync_on_gnt", (gnt_cyc.size() > 0 && cap_cyc.size() > 0) ? gnt_cyc[0] - cap_cyc[0] : -1, 0);
    chk("t1_gnt_dropped", s0_gnt, 0);
    clr_cap();

    // same packet, FIFO full for 5 cycles in LEN_HI and again at payload byte 2
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_byte(0, t1[i]);
    len0.push_back(3); m_len0.push_back(3);
    wait_cap(2, "t3_reach_lh");
    @(posedge clk); #1 force_full = 1;
    repeat (5) @(posedge clk);
    #1 force_full = 0;
    wait_cap(5, "t3_reach_b2");
    @(posedge clk); #1 force_full = 1;
    repeat (5) @(posedge clk);
    #1 force_full = 0;
    run_batch("t3", 200);
    span = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[0] : -1;
    chk("t3_span", span, nb - 1 + 10);
    chk("t3_wr_while_full", wr_full_err, 0);
    clr_cap();

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      @(posedge clk); #1;
      vmode = tbl[k].vm;
      fmode = tbl[k].fm;
      r0 = rdy1_cnt;
      for (int i = 0; i < tbl[k].n0; i++) add_pkt(0, tbl[k].l0);
      for (int i = 0; i < tbl[k].n1; i++) add_pkt(1, tbl[k].l1);
      run_batch($sformatf("vec%0d", k), 3000);
      chk($sformatf("vec%0d_first", k), (gnt_ord.size() > 0) ? gnt_ord[0] : -1, tbl[k].first);
      if (tbl[k].nordy1) chk($sformatf("vec%0d_no_ready1", k), rdy1_cnt - r0, 0);
      clr_cap();
    end

    for (int it = 0; it < 15; it++) begin
      @(posedge clk); #1;
      vmode = $urandom_range(2);
      fmode = $urandom_range(1) == 1;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(1) == 1) add_pkt(0, $urandom_range(20));
        if ($urandom_range(1) == 1) add_pkt(1, $urandom_range(20));
      end
      run_batch($sformatf("rnd%0d", it), 3000);
      clr_cap();
    end
    chk("wr_while_full_total", wr_full_err, 0);
    chk("dual_gnt_total", both_gnt_err, 0);

    // reset in the middle of a payload
    fmode = 0; vmode = 0;
    @(posedge clk); #1;
    add_pkt(0, 10);
    wait_cap(6, "t6_reach_b2");
    @(posedge clk); #3 nrst = 0;
    #1;
    chk("t6_wrreq", tx_wrreq, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_gnt", {s1_gnt, s0_gnt}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", {s1_ready, s0_ready}, 0);
    len0.delete(); pay0.delete(); m_len0.delete(); m_pay0.delete();
    clr_cap();
    mlast = 1;
    repeat (2) @(posedge clk);
    #1 nrst = 1;
    @(posedge clk); #1;
    add_pkt(1, 4);
    run_batch("t6_after", 200);
    chk("t6_first_byte", (cap.size() > 0) ? cap[0] : -1, 8'hA5);
    clr_cap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
